// File: rtl/sram_controller.sv
// Bus slave driving a 16-bit asynchronous SRAM: one request at a time, programmable strobe
// widths, registered pins and a single-cycle acknowledge.
//   state   | meaning
//   S_IDLE  | waiting for m_access_i & cs_i; strobes inactive
//   S_READ  | CE/OE low, counting read wait states
//   S_WRITE | CE/WE low, data driven, counting write wait states
//   S_HOLD  | WE high again, CE and data held for one cycle
//   S_TURN  | ack cycle; request line ignored so a held request is not re-accepted
module sram_controller #(
  parameter int ADDR_WIDTH = 18,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  cs_i,
  input  logic [19:1]           m_addr_i,
  input  logic [15:0]           m_data_in_i,
  output logic [15:0]           m_data_out_o,
  input  logic                  m_access_i,
  output logic                  m_ack_o,
  input  logic                  m_wr_en_i,
  input  logic [1:0]            m_bytesel_i,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  input  logic [15:0]           sram_dq_in_i,
  output logic [15:0]           sram_dq_out_o,
  output logic                  sram_dq_oe_o,
  output logic                  sram_ce_n_o,
  output logic                  sram_oe_n_o,
  output logic                  sram_we_n_o,
  output logic                  sram_ub_n_o,
  output logic                  sram_lb_n_o
);

  localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_WAIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_HOLD, S_TURN} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           dq_out_q, dq_out_d;
  logic [15:0]           rdata_q, rdata_d;
  logic                  dq_oe_q, dq_oe_d;
  logic                  ce_n_q, ce_n_d;
  logic                  oe_n_q, oe_n_d;
  logic                  we_n_q, we_n_d;
  logic                  ub_n_q, ub_n_d;
  logic                  lb_n_q, lb_n_d;
  logic                  ack_q, ack_d;

  // Address bits above the SRAM width are dropped, so accesses wrap.
  if (ADDR_WIDTH < 19) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = |m_addr_i[19:ADDR_WIDTH+1];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      dq_out_q <= '0;
      rdata_q  <= '0;
      dq_oe_q  <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      dq_out_q <= dq_out_d;
      rdata_q  <= rdata_d;
      dq_oe_q  <= dq_oe_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      ub_n_q   <= ub_n_d;
      lb_n_q   <= lb_n_d;
      ack_q    <= ack_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    rdata_d  = rdata_q;
    dq_oe_d  = dq_oe_q;
    ce_n_d   = ce_n_q;
    oe_n_d   = oe_n_q;
    we_n_d   = we_n_q;
    ub_n_d   = ub_n_q;
    lb_n_d   = lb_n_q;
    ack_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Strobes go active on the accepting edge; pins are all registered.
        if (m_access_i && cs_i) begin
          addr_d   = m_addr_i[ADDR_WIDTH:1];
          dq_out_d = m_data_in_i;
          ce_n_d   = 1'b0;
          ub_n_d   = ~m_bytesel_i[1];
          lb_n_d   = ~m_bytesel_i[0];
          if (m_wr_en_i) begin
            we_n_d  = 1'b0;
            dq_oe_d = 1'b1;
            cnt_d   = WR_LOAD;
            state_d = S_WRITE;
          end else begin
            oe_n_d  = 1'b0;
            cnt_d   = RD_LOAD;
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (cnt_q == '0) begin
          rdata_d = sram_dq_in_i;
          ack_d   = 1'b1;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          ub_n_d  = 1'b1;
          lb_n_d  = 1'b1;
          state_d = S_TURN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WRITE: begin
        if (cnt_q == '0) begin
          we_n_d  = 1'b1;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        ack_d   = 1'b1;
        ce_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        ub_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        state_d = S_TURN;
      end
      S_TURN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign m_data_out_o  = rdata_q;
  assign m_ack_o       = ack_q;
  assign sram_addr_o   = addr_q;
  assign sram_dq_out_o = dq_out_q;
  assign sram_dq_oe_o  = dq_oe_q;
  assign sram_ce_n_o   = ce_n_q;
  assign sram_oe_n_o   = oe_n_q;
  assign sram_we_n_o   = we_n_q;
  assign sram_ub_n_o   = ub_n_q;
  assign sram_lb_n_o   = lb_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: pin-level SRAM model, word-level reference memory and an
// ack-driven scoreboard checking completion cycle and returned data.
module tb_sram_controller;
  localparam int AW = 18;
  localparam int RW = 2;
  localparam int WW = 2;

  logic          clk_i = 1'b0;
  logic          reset_i, cs_i, m_access_i, m_wr_en_i;
  logic [19:1]   m_addr_i;
  logic [15:0]   m_data_in_i, m_data_out_o;
  logic          m_ack_o;
  logic [1:0]    m_bytesel_i;
  logic [AW-1:0] sram_addr_o;
  logic [15:0]   sram_dq_in_i, sram_dq_out_o;
  logic          sram_dq_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o;

  sram_controller #(.ADDR_WIDTH(AW), .READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .cs_i(cs_i), .m_addr_i(m_addr_i),
    .m_data_in_i(m_data_in_i), .m_data_out_o(m_data_out_o), .m_access_i(m_access_i),
    .m_ack_o(m_ack_o), .m_wr_en_i(m_wr_en_i), .m_bytesel_i(m_bytesel_i),
    .sram_addr_o(sram_addr_o), .sram_dq_in_i(sram_dq_in_i), .sram_dq_out_o(sram_dq_out_o),
    .sram_dq_oe_o(sram_dq_oe_o), .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o),
    .sram_we_n_o(sram_we_n_o), .sram_ub_n_o(sram_ub_n_o), .sram_lb_n_o(sram_lb_n_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    bit          wr;
  } exp_t;
  exp_t sb[$];

  logic [15:0] ref_mem [int];
  logic [15:0] pin_mem [int];
  logic [15:0] last_rd;

  function automatic logic [15:0] init_word(input int a);
    return 16'(a * 40503) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Asynchronous SRAM at the pins: drives data only while CE/OE are low, writes on WE rising.
  bit prev_we_n = 1'b1;
  always @(negedge clk_i) begin
    int          a;
    logic [15:0] w;
    a = int'(sram_addr_o);
    if (!sram_ce_n_o && !sram_oe_n_o)
      sram_dq_in_i = pin_mem.exists(a) ? pin_mem[a] : init_word(a);
    else
      sram_dq_in_i = 16'($urandom);
    if (!prev_we_n && sram_we_n_o && !sram_ce_n_o && sram_dq_oe_o) begin
      w = pin_mem.exists(a) ? pin_mem[a] : init_word(a);
      if (!sram_ub_n_o) w[15:8] = sram_dq_out_o[15:8];
      if (!sram_lb_n_o) w[7:0]  = sram_dq_out_o[7:0];
      pin_mem[a] = w;
    end
    prev_we_n = sram_we_n_o;
  end

  always @(negedge clk_i) begin
    exp_t e;
    if (!reset_i && m_ack_o) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: m_ack_o=1 at cycle %0d, expected no ack", cyc);
      end else begin
        e = sb.pop_front();
        chk(e.wr ? "wr_ack_cycle" : "rd_ack_cycle", cyc, e.cyc);
        chk(e.wr ? "wr_data_out_hold" : "rd_data", m_data_out_o, e.data);
      end
    end
  end

  logic [AW-1:0] first_addr;
  int c_ce, c_oe, c_we, c_hold, c_ub, c_lb;
  bit got_ack;

  // Present a request at the current negedge; off=1 when the DUT is in its turnaround cycle.
  task automatic start_req(input bit wr, input logic [19:1] a, input logic [15:0] d,
                           input logic [1:0] be, input int off, input bit track);
    logic [15:0] w;
    int          wa;
    exp_t        e;
    cs_i = 1'b1; m_access_i = 1'b1; m_wr_en_i = wr;
    m_addr_i = a; m_data_in_i = d; m_bytesel_i = be;
    if (track) begin
      wa   = int'(a[AW:1]);
      w    = ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
      e.wr = wr;
      if (wr) begin
        if (be[1]) w[15:8] = d[15:8];
        if (be[0]) w[7:0]  = d[7:0];
        ref_mem[wa] = w;
        e.data = last_rd;
        e.cyc  = cyc + off + WW + 2;
      end else begin
        last_rd = w;
        e.data  = w;
        e.cyc   = cyc + off + RW + 1;
      end
      sb.push_back(e);
    end
  endtask

  task automatic wait_ack(input bit scramble, input int off);
    c_ce = 0; c_oe = 0; c_we = 0; c_hold = 0; c_ub = 0; c_lb = 0;
    got_ack = 1'b0;
    for (int i = 0; i < 40 && !got_ack; i++) begin
      @(negedge clk_i);
      if (i == off) first_addr = sram_addr_o;
      if (!sram_ce_n_o) c_ce++;
      if (!sram_oe_n_o) c_oe++;
      if (!sram_we_n_o) c_we++;
      if (!sram_ub_n_o) c_ub++;
      if (!sram_lb_n_o) c_lb++;
      if (!sram_ce_n_o && sram_we_n_o && sram_dq_oe_o) c_hold++;
      if (m_ack_o) got_ack = 1'b1;
      else if (scramble && i >= off) begin
        m_addr_i    = 19'($urandom);
        m_data_in_i = 16'($urandom);
        m_bytesel_i = 2'($urandom);
      end
    end
    if (!got_ack) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout: m_ack_o never rose within 40 cycles, expected 1");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [19:0] ba;
    logic [19:1] ra;
    int          extra, strb, word, gap;
    bit          chain, wr;

    reset_i = 1'b1; cs_i = 1'b0; m_access_i = 1'b0; m_wr_en_i = 1'b0;
    m_addr_i = '0; m_data_in_i = '0; m_bytesel_i = '0; sram_dq_in_i = '0;
    last_rd = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_strobes", {sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o}, 5'b11111);
    chk("rst_dq_oe", sram_dq_oe_o, 0);
    chk("rst_ack", m_ack_o, 0);
    chk("rst_data_out", m_data_out_o, 0);
    chk("rst_sram_addr", sram_addr_o, 0);
    chk("rst_dq_out", sram_dq_out_o, 0);
    reset_i = 1'b0;
    @(negedge clk_i);

    ref_mem[8] = 16'hBEEF;
    pin_mem[8] = 16'hBEEF;
    ba = 20'h00010;
    start_req(1'b0, ba[19:1], 16'h0000, 2'b11, 0, 1'b1);
    wait_ack(1'b0, 0);
    m_access_i = 1'b0;
    chk("rd_sram_addr", first_addr, 18'h00008);
    chk("rd_ce_low_cycles", c_ce, RW);
    chk("rd_oe_low_cycles", c_oe, RW);
    chk("rd_we_low_cycles", c_we, 0);
    @(negedge clk_i);

    ba = 20'h00020;
    start_req(1'b1, ba[19:1], 16'h1234, 2'b10, 0, 1'b1);
    wait_ack(1'b1, 0);
    m_access_i = 1'b0;
    chk("wr_sram_addr", first_addr, 18'h00010);
    chk("wr_we_low_cycles", c_we, WW);
    chk("wr_hold_cycles", c_hold, 1);
    chk("wr_ub_low_cycles", c_ub, WW + 1);
    chk("wr_lb_low_cycles", c_lb, 0);
    chk("wr_oe_low_cycles", c_oe, 0);
    @(negedge clk_i);
    start_req(1'b0, ba[19:1], 16'h0000, 2'b01, 0, 1'b1);
    wait_ack(1'b0, 0);
    m_access_i = 1'b0;
    @(negedge clk_i);

    ba = 20'h00030;
    start_req(1'b1, ba[19:1], 16'hFFFF, 2'b00, 0, 1'b1);
    wait_ack(1'b0, 0);
    m_access_i = 1'b0;
    chk("be00_we_low_cycles", c_we, WW);
    chk("be00_byte_en_cycles", c_ub + c_lb, 0);
    @(negedge clk_i);
    start_req(1'b0, ba[19:1], 16'h0000, 2'b00, 0, 1'b1);
    wait_ack(1'b0, 0);
    m_access_i = 1'b0;
    @(negedge clk_i);

    // Request held through the ack, then a new one presented during the turnaround.
    ba = 20'h00010;
    start_req(1'b0, ba[19:1], 16'h0000, 2'b11, 0, 1'b1);
    wait_ack(1'b0, 0);
    ba = 20'h00020;
    start_req(1'b0, ba[19:1], 16'h0000, 2'b11, 1, 1'b1);
    wait_ack(1'b0, 1);
    @(negedge clk_i);
    m_access_i = 1'b0;
    extra = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (m_ack_o) extra++;
    end
    chk("held_req_extra_acks", extra, 0);

    cs_i = 1'b0; m_access_i = 1'b1; m_wr_en_i = 1'b1;
    strb = 0; extra = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (!sram_ce_n_o || !sram_oe_n_o || !sram_we_n_o || sram_dq_oe_o) strb++;
      if (m_ack_o) extra++;
    end
    chk("cs0_strobe_cycles", strb, 0);
    chk("cs0_acks", extra, 0);
    m_access_i = 1'b0; cs_i = 1'b1;
    @(negedge clk_i);

    ba = 20'h00040;
    start_req(1'b1, ba[19:1], 16'hA5A5, 2'b11, 0, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    chk("rstw_we_n", sram_we_n_o, 1);
    chk("rstw_ce_n", sram_ce_n_o, 1);
    chk("rstw_dq_oe", sram_dq_oe_o, 0);
    chk("rstw_ack", m_ack_o, 0);
    chk("rstw_data_out", m_data_out_o, 0);
    reset_i = 1'b0; m_access_i = 1'b0;
    last_rd = '0;
    @(negedge clk_i);
    start_req(1'b0, ba[19:1], 16'h0000, 2'b11, 0, 1'b1);
    wait_ack(1'b0, 0);
    m_access_i = 1'b0;
    @(negedge clk_i);

    chain = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (!chain) begin
        if ($urandom_range(0, 7) == 0) begin
          cs_i = 1'b0; m_access_i = 1'b1;
          repeat (3) @(negedge clk_i);
          m_access_i = 1'b0; cs_i = 1'b1;
        end
        gap = $urandom_range(0, 2);
        repeat (gap) @(negedge clk_i);
      end
      word = $urandom_range(0, 15) | ($urandom_range(0, 1) << 17);
      ra   = {1'($urandom_range(0, 1)), 18'(word)};
      wr   = 1'($urandom_range(0, 1));
      start_req(wr, ra, 16'($urandom), 2'($urandom), chain ? 1 : 0, 1'b1);
      wait_ack(1'($urandom_range(0, 1)), chain ? 1 : 0);
      if (!chain) chk("rand_sram_addr", first_addr, ra[AW:1]);
      chain = ($urandom_range(0, 3) == 0);
      if (!chain) begin
        m_access_i = 1'b0;
        @(negedge clk_i);
      end
    end
    m_access_i = 1'b0;
    repeat (8) @(negedge clk_i);
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
